pipeline_hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage OTTER pipeline (F/D/E/M/W). Generates operand-forward selects,

---
 rtl/pipeline_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forward selects, RAW/branch stall-flush and data-memory wait control
module pipeline_hazard_ctrl #(
  parameter int AW          = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    i_rs1_d,
  input  logic [AW-1:0]    i_rs2_d,
  input  logic [AW-1:0]    i_rs1_e,
  input  logic [AW-1:0]    i_rs2_e,
  input  logic [AW-1:0]    i_rd_e,
  input  logic [AW-1:0]    i_rd_m,
  input  logic [AW-1:0]    i_rd_w,
  input  logic             i_reg_wr_e,
  input  logic             i_reg_wr_m,
  input  logic             i_reg_wr_w,
  input  logic             i_mem_rd_e,
  input  logic             i_br_taken_e,
  input  logic             i_dmem_req_m,
  input  logic             i_dmem_ack_m,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout_err
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           r_state, w_next;
  logic [WW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout;
  logic             w_wait, w_hit_e, w_hit_m, w_raw, w_tmo, w_fwd_on;
  assign w_wait   = r_state == MEM_WAIT;
  assign w_fwd_on = rst_n && FWD_EN != 0;
  assign w_tmo    = r_wait_cnt == WW'(MEM_TIMEOUT);
  assign w_hit_e  = i_reg_wr_e && i_rd_e != '0 && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
  assign w_hit_m  = i_reg_wr_m && i_rd_m != '0 && (i_rd_m == i_rs1_d || i_rd_m == i_rs2_d);
  // Without forwarding any producer still in E or M must drain before D may read
  assign w_raw    = FWD_EN != 0 ? (i_mem_rd_e && w_hit_e) : (w_hit_e || w_hit_m);
  assign o_fwd_a  = !w_fwd_on ? 2'b00 :
                    (i_reg_wr_m && i_rd_m != '0 && i_rd_m == i_rs1_e) ? 2'b01 :
                    (i_reg_wr_w && i_rd_w != '0 && i_rd_w == i_rs1_e) ? 2'b10 : 2'b00;
  assign o_fwd_b  = !w_fwd_on ? 2'b00 :
                    (i_reg_wr_m && i_rd_m != '0 && i_rd_m == i_rs2_e) ? 2'b01 :
                    (i_reg_wr_w && i_rd_w != '0 && i_rd_w == i_rs2_e) ? 2'b10 : 2'b00;
  assign o_stall_f = rst_n && (w_wait || (!i_br_taken_e && w_raw));
  assign o_stall_d = o_stall_f;
  assign o_stall_e = rst_n && w_wait;
  assign o_stall_m = o_stall_e;
  assign o_flush_w = o_stall_e;
  assign o_flush_d = !rst_n || (!w_wait && i_br_taken_e);
  assign o_flush_e = !rst_n || (!w_wait && (i_br_taken_e || w_raw));
  assign o_stall_cnt   = r_stall_cnt;
  assign o_timeout_err = r_timeout;
  always_comb begin
    w_next = r_state;
    if (!w_wait && i_dmem_req_m && !i_dmem_ack_m) w_next = MEM_WAIT;
    if (w_wait && (i_dmem_ack_m || w_tmo)) w_next = RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_next == MEM_WAIT ? (w_wait ? r_wait_cnt + WW'(1) : WW'(1)) : '0;
      if (o_stall_f && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_wait && !i_dmem_ack_m && w_tmo) r_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random stimulus vs a rule-level model, two configurations
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_wr_e, reg_wr_m, reg_wr_w, mem_rd_e, br_e, req_m, ack_m;
  logic [1:0] sf, sd, se, sm, fd, fe, fw, te;
  logic [1:0] fa0, fa1, fb0, fb1;
  logic [3:0] cnt0;
  logic [31:0] cnt1;
  int errors = 0, checks = 0;
  bit m_wait[2], m_te[2], m_stall[2];
  int m_wc[2];
  longint m_sc[2];
  longint m_max[2] = '{15, 64'hFFFF_FFFF};

  pipeline_hazard_ctrl #(.AW(5), .FWD_EN(0), .MEM_TIMEOUT(8), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w), .i_reg_wr_e(reg_wr_e), .i_reg_wr_m(reg_wr_m),
    .i_reg_wr_w(reg_wr_w), .i_mem_rd_e(mem_rd_e), .i_br_taken_e(br_e), .i_dmem_req_m(req_m),
    .i_dmem_ack_m(ack_m), .o_stall_f(sf[0]), .o_stall_d(sd[0]), .o_stall_e(se[0]), .o_stall_m(sm[0]),
    .o_flush_d(fd[0]), .o_flush_e(fe[0]), .o_flush_w(fw[0]), .o_fwd_a(fa0), .o_fwd_b(fb0),
    .o_stall_cnt(cnt0), .o_timeout_err(te[0]));
  pipeline_hazard_ctrl #(.AW(5), .FWD_EN(1), .MEM_TIMEOUT(8), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w), .i_reg_wr_e(reg_wr_e), .i_reg_wr_m(reg_wr_m),
    .i_reg_wr_w(reg_wr_w), .i_mem_rd_e(mem_rd_e), .i_br_taken_e(br_e), .i_dmem_req_m(req_m),
    .i_dmem_ack_m(ack_m), .o_stall_f(sf[1]), .o_stall_d(sd[1]), .o_stall_e(se[1]), .o_stall_m(sm[1]),
    .o_flush_d(fd[1]), .o_flush_e(fe[1]), .o_flush_w(fw[1]), .o_fwd_a(fa1), .o_fwd_b(fb1),
    .o_stall_cnt(cnt1), .o_timeout_err(te[1]));

  task automatic chk(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h t=%0t", tag, u, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] efwd(bit f, logic [4:0] rs);
    if (!f || !rst_n) return 2'b00;
    if (reg_wr_m && rd_m != 0 && rd_m == rs) return 2'b01;
    if (reg_wr_w && rd_w != 0 && rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit reads_d(logic [4:0] r);
    return r != 0 && (r == rs1_d || r == rs2_d);
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit raw, esf, ese, efd, efe, efw;
      raw = i == 1 ? (mem_rd_e && reg_wr_e && reads_d(rd_e))
                   : ((reg_wr_e && reads_d(rd_e)) || (reg_wr_m && reads_d(rd_m)));
      if (!rst_n) begin
        esf = 0; ese = 0; efw = 0; efd = 1; efe = 1;
      end else if (m_wait[i]) begin
        esf = 1; ese = 1; efw = 1; efd = 0; efe = 0;
      end else begin
        ese = 0; efw = 0; efd = br_e; efe = br_e || raw; esf = !br_e && raw;
      end
      m_stall[i] = esf;
      chk("stallF", i, sf[i], esf);
      chk("stallD", i, sd[i], esf);
      chk("stallE", i, se[i], ese);
      chk("stallM", i, sm[i], ese);
      chk("flushD", i, fd[i], efd);
      chk("flushE", i, fe[i], efe);
      chk("flushW", i, fw[i], efw);
      chk("fwdA", i, i == 1 ? fa1 : fa0, efwd(i == 1, rs1_e));
      chk("fwdB", i, i == 1 ? fb1 : fb0, efwd(i == 1, rs2_e));
      chk("stallCnt", i, i == 1 ? 64'(cnt1) : 64'(cnt0), m_sc[i]);
      chk("timeoutErr", i, te[i], m_te[i]);
    end
  endtask

  task automatic update_model();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (m_stall[i] && m_sc[i] < m_max[i]) m_sc[i]++;
      if (m_wait[i]) begin
        if (ack_m) m_wait[i] = 0;
        else if (m_wc[i] == 8) begin m_wait[i] = 0; m_te[i] = 1; end
        else m_wc[i]++;
      end else if (req_m && !ack_m) begin
        m_wait[i] = 1; m_wc[i] = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic reset_low();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin m_wait[i] = 0; m_wc[i] = 0; m_sc[i] = 0; m_te[i] = 0; end
  endtask

  task automatic clr();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_wr_e, reg_wr_m, reg_wr_w, mem_rd_e, br_e, req_m, ack_m} = '0;
  endtask

  initial begin
    clr(); reset_low();
    cycle();
    chk("resetFlushD", 1, fd[1], 1'b1);
    rst_n = 1'b1;
    cycle();
    // load-use: lw x5 in E, add x6,x5,x1 in D
    mem_rd_e = 1; reg_wr_e = 1; rd_e = 5; rs1_d = 5; rs2_d = 1;
    cycle();
    clr(); reg_wr_m = 1; rd_m = 5; rs1_e = 5; rs2_e = 1;
    cycle();
    chk("loadUseFwdA", 1, fa1, 2'b01);
    // M beats W; x0 never forwarded
    clr(); reg_wr_m = 1; reg_wr_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7;
    cycle();
    clr(); reg_wr_m = 1; rd_m = 0; rs2_e = 0; reg_wr_w = 1; rd_w = 0;
    cycle();
    clr(); reg_wr_w = 1; rd_w = 9; rs2_e = 9;
    cycle();
    // no-forwarding RAW: producer in E then in M
    clr(); reg_wr_e = 1; rd_e = 3; rs2_d = 3;
    cycle();
    clr(); reg_wr_m = 1; rd_m = 3; rs2_d = 3;
    cycle();
    clr();
    cycle();
    chk("rawStallCnt", 0, 64'(cnt0), 64'd3);
    // memory wait acked on the fourth wait cycle
    req_m = 1;
    cycle();
    repeat (3) cycle();
    ack_m = 1;
    cycle();
    clr();
    cycle();
    // same-cycle ack: no wait
    req_m = 1; ack_m = 1;
    cycle();
    // timeout after 8 wait cycles, sticky
    clr(); req_m = 1;
    repeat (10) cycle();
    clr();
    repeat (3) cycle();
    chk("timeoutSticky", 1, te[1], 1'b1);
    // branch beats load-use
    mem_rd_e = 1; reg_wr_e = 1; rd_e = 4; rs1_d = 4; br_e = 1;
    cycle();
    // branch held in E during a memory wait, then reset mid-wait
    clr(); br_e = 1; req_m = 1;
    repeat (3) cycle();
    reset_low();
    cycle();
    rst_n = 1'b1; clr();
    cycle();
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      reg_wr_e = 1'($urandom); reg_wr_m = 1'($urandom); reg_wr_w = 1'($urandom);
      mem_rd_e = 1'($urandom); br_e = $urandom_range(0, 4) == 0;
      req_m = $urandom_range(0, 3) == 0; ack_m = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 199) == 0) reset_low();
      else rst_n = 1'b1;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
